// File: rtl/my_nios1_leds.sv
// my_nios1_leds: Avalon-MM LED output port with set/clear aliases and a
// hardware blinker that XORs a masked square wave onto the LED pattern.
module my_nios1_leds #(
  parameter logic [7:0]  RESET_VALUE  = 8'h00,
  parameter logic [15:0] PERIOD_RESET = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [7:0]  data;
  logic [7:0]  blink_mask;
  logic [15:0] period;
  logic [15:0] count;
  logic        phase;

  logic        wr_en;
  logic        wr_data;
  logic        wr_set;
  logic        wr_clear;
  logic        wr_mask;
  logic        wr_period;
  logic [15:0] unused_wdata_bits;

  // Write strobes: only an addressed, selected, active-low write reaches a register.
  always_comb begin
    wr_en     = chipselect & ~write_n;
    wr_data   = wr_en && (address == ADDR_DATA);
    wr_mask   = wr_en && (address == ADDR_MASK);
    wr_period = wr_en && (address == ADDR_PERIOD);
    wr_set    = wr_en && (address == ADDR_OUTSET);
    wr_clear  = wr_en && (address == ADDR_OUTCLEAR);
  end

  // The top half of the bus is never stored anywhere.
  assign unused_wdata_bits = writedata[31:16];

  // LED pattern register, loadable directly or through the set/clear aliases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr_data) begin
      data <= writedata[7:0];
    end else if (wr_set) begin
      data <= data | writedata[7:0];
    end else if (wr_clear) begin
      data <= data & ~writedata[7:0];
    end
  end

  // Selects which LEDs blink; changing it leaves the blink timing alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= 8'h00;
    end else if (wr_mask) begin
      blink_mask <= writedata[7:0];
    end
  end

  // Blink timebase: a PERIOD write restarts it, a zero PERIOD parks it at phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= PERIOD_RESET;
      count  <= 16'd0;
      phase  <= 1'b0;
    end else if (wr_period) begin
      period <= writedata[15:0];
      count  <= 16'd0;
      phase  <= 1'b0;
    end else if (period == 16'd0) begin
      count <= 16'd0;
      phase <= 1'b0;
    end else if (count == period) begin
      count <= 16'd0;
      phase <= ~phase;
    end else begin
      count <= count + 16'd1;
    end
  end

  // Read port is sampled every clock from the current address, one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      case (address)
        ADDR_DATA:   readdata <= {24'd0, data};
        ADDR_MASK:   readdata <= {24'd0, blink_mask};
        ADDR_PERIOD: readdata <= {16'd0, period};
        ADDR_STATUS: readdata <= {31'd0, phase};
        default:     readdata <= 32'd0;
      endcase
    end
  end

  assign out_port = data ^ (blink_mask & {8{phase}});

endmodule

// File: tb/tb_my_nios1_leds.sv
// tb_my_nios1_leds: directed scoreboard bench for the LED port.
// Stimulus pushes expectations tagged with the cycle they apply to; a
// separate monitor pops and compares them on the falling edge.
module tb_my_nios1_leds;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  my_nios1_leds dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to tag expectations.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic wr, input logic [2:0] addr,
                               input logic [31:0] wd);
    @(negedge clk);
    chipselect = cs;
    write_n    = ~wr;
    address    = addr;
    writedata  = wd;
  endtask

  task automatic expectAt(input int offset, input bit is_rd, input logic [31:0] exp,
                          input string name);
    exp_t e;
    e.cyc   = cyc + offset;
    e.is_rd = is_rd;
    e.exp   = exp;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  initial begin : monitor
    int i;
    forever begin
      @(negedge clk);
      #1;
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc == cyc) begin
          checkOutput(sb[i].name, sb[i].is_rd ? readdata : {24'd0, out_port}, sb[i].exp);
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Directed stimulus.
  initial begin
    int ph_now;
    int ph_next;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_port", {24'd0, out_port}, 32'h00);
    checkOutput("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;

    // Reset values on the read port.
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1'b0, 1'b0, 3'(a), 32'd0);
      expectAt(1, 1'b1, 32'h0, "reset_read");
      expectAt(1, 1'b0, 32'h0, "reset_out");
    end

    // Load, set and clear aliases: A5 | 0F = AF, AF & ~81 = 2E.
    applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_00A5);
    expectAt(1, 1'b0, 32'hA5, "data_load");
    applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_000F);
    expectAt(1, 1'b0, 32'hAF, "outset");
    expectAt(1, 1'b1, 32'h0, "read_outset_addr");
    applyStimulus(1'b1, 1'b1, 3'd5, 32'h0000_0081);
    expectAt(1, 1'b0, 32'h2E, "outclear");
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    expectAt(1, 1'b1, 32'h2E, "read_data");

    // Ignored writes: chipselect low, reserved and read-only addresses.
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h0000_00FF);
    expectAt(1, 1'b0, 32'h2E, "cs_low_write");
    applyStimulus(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF);
    expectAt(1, 1'b1, 32'h0, "read_addr6");
    applyStimulus(1'b1, 1'b1, 3'd3, 32'h0000_00FF);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    expectAt(1, 1'b1, 32'h2E, "data_after_ignored");
    applyStimulus(1'b0, 1'b0, 3'd1, 32'd0);
    expectAt(1, 1'b1, 32'h0, "mask_after_ignored");
    applyStimulus(1'b0, 1'b0, 3'd2, 32'd0);
    expectAt(1, 1'b1, 32'h0, "period_after_ignored");
    applyStimulus(1'b1, 1'b1, 3'd0, 32'hFFFF_FF12);
    expectAt(1, 1'b0, 32'h12, "upper_bits_ignored_out");
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    expectAt(1, 1'b1, 32'h12, "upper_bits_ignored_rd");

    // Blink with PERIOD 3: four cycles per phase.
    applyStimulus(1'b1, 1'b1, 3'd0, 32'h00);
    applyStimulus(1'b1, 1'b1, 3'd1, 32'h03);
    applyStimulus(1'b1, 1'b1, 3'd2, 32'h03);
    expectAt(1, 1'b0, 32'h00, "blink_out");
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(1'b0, 1'b0, 3'd3, 32'd0);
      ph_now  = ((k - 1) / 4) % 2;
      ph_next = (k / 4) % 2;
      expectAt(1, 1'b0, (ph_next != 0) ? 32'h03 : 32'h00, "blink_out");
      expectAt(1, 1'b1, 32'(ph_now), "blink_status");
    end

    // PERIOD 0 written while phase is 1 parks the blinker immediately.
    applyStimulus(1'b1, 1'b1, 3'd2, 32'h0);
    expectAt(1, 1'b0, 32'h00, "period0_out");
    applyStimulus(1'b0, 1'b0, 3'd3, 32'd0);
    expectAt(1, 1'b1, 32'h0, "period0_status");
    applyStimulus(1'b1, 1'b1, 3'd0, 32'h50);
    expectAt(1, 1'b0, 32'h50, "frozen_data");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 3'd3, 32'd0);
      expectAt(1, 1'b0, 32'h50, "frozen_out");
      expectAt(1, 1'b1, 32'h0, "frozen_status");
    end

    // PERIOD 1: OUTSET on the toggle edge, then a mask write mid-blink.
    applyStimulus(1'b1, 1'b1, 3'd2, 32'h1);
    expectAt(1, 1'b0, 32'h50, "p1_phase0");
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    expectAt(1, 1'b0, 32'h50, "p1_phase0_b");
    applyStimulus(1'b1, 1'b1, 3'd4, 32'h0C);
    expectAt(1, 1'b0, 32'h5F, "set_on_toggle");
    applyStimulus(1'b0, 1'b0, 3'd3, 32'd0);
    expectAt(1, 1'b0, 32'h5F, "p1_phase1");
    expectAt(1, 1'b1, 32'h1, "p1_status");
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    expectAt(1, 1'b0, 32'h5C, "p1_toggle_back");
    applyStimulus(1'b1, 1'b1, 3'd1, 32'hF0);
    expectAt(1, 1'b0, 32'h5C, "mask_write_keeps_timing");
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    expectAt(1, 1'b0, 32'hAC, "new_mask_toggle");
    expectAt(1, 1'b1, 32'h5C, "read_data_p1");

    // Asynchronous reset between edges, mid-blink.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out", {24'd0, out_port}, 32'h00);
    checkOutput("async_reset_rd", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    expectAt(1, 1'b1, 32'h0, "post_reset_data");
    applyStimulus(1'b0, 1'b0, 3'd1, 32'd0);
    expectAt(1, 1'b1, 32'h0, "post_reset_mask");
    applyStimulus(1'b0, 1'b0, 3'd3, 32'd0);
    expectAt(1, 1'b1, 32'h0, "post_reset_status");
    expectAt(1, 1'b0, 32'h00, "post_reset_out");

    repeat (3) @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/my_nios1_leds.md
MY_NIOS1_LEDS -- requirements
Module: my_nios1_leds

Interface
REQ-001 Parameter RESET_VALUE, default 8'h00, the DATA register value after reset.
REQ-002 Parameter PERIOD_RESET, default 16'd0, the PERIOD register value after reset (0 = blink disabled).
REQ-003 clk  input  1  single clock; all state SHALL be updated on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select, active-high.
REQ-007 write_n  input  1  write strobe, active-low; write = chipselect & ~write_n.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.
REQ-010 out_port  output  8  LED drive.

Function
REQ-011 Register map: 0 DATA rw [7:0]; 1 BLINK_MASK rw [7:0]; 2 PERIOD rw [15:0]; 3 STATUS ro (bit0 = phase); 4 OUTSET wo; 5 OUTCLEAR wo; 6-7 reserved.
REQ-012 Write to 0 SHALL load DATA <= writedata[7:0] on the write edge.
REQ-013 Write to 4 SHALL set DATA <= DATA | writedata[7:0].
REQ-014 Write to 5 SHALL clear DATA <= DATA & ~writedata[7:0].
REQ-015 Write to 1 SHALL load BLINK_MASK <= writedata[7:0].
REQ-016 Write to 2 SHALL load PERIOD <= writedata[15:0] and, on the same edge, clear count to 0 and phase to 0.
REQ-017 Writes to 3, 6, 7 SHALL have no effect; upper writedata bits SHALL be ignored.
REQ-018 readdata SHALL be updated every clock, independent of chipselect, from the current address: 0 -> {24'b0,DATA}; 1 -> {24'b0,BLINK_MASK}; 2 -> {16'b0,PERIOD}; 3 -> {31'b0,phase}; 4-7 -> 0. Read latency is 1 clock.
REQ-019 out_port SHALL be combinational: DATA ^ (BLINK_MASK & {8{phase}}).
REQ-020 Blink counter: 16-bit count. If PERIOD == 0, count and phase SHALL hold at 0.
REQ-021 If PERIOD != 0: when count == PERIOD, count <= 0 and phase toggles; otherwise count <= count + 1. Phase period is 2*(PERIOD+1) clocks.
REQ-022 Lowering PERIOD below the current count SHALL take effect through REQ-016 (the write clears count); no wrap past 16'hFFFF occurs.
REQ-023 A DATA/OUTSET/OUTCLEAR write on the same edge as a phase toggle SHALL apply both; out_port on the next cycle reflects the new DATA and new phase.
REQ-024 A write to DATA or BLINK_MASK SHALL NOT disturb count or phase.
REQ-025 A write with chipselect low SHALL have no effect.

Reset
REQ-026 On reset_n low, asynchronously: DATA = RESET_VALUE, BLINK_MASK = 0, PERIOD = PERIOD_RESET, count = 0, phase = 0, readdata = 0; out_port = RESET_VALUE.
REQ-027 Reset asserted mid-blink SHALL force phase 0 immediately; after release, counting restarts from 0 on the first clock edge.

Verification
REQ-028 Reset, then read addresses 0-3 -> readdata 0x00, 0x00, 0x0000, 0 one clock after each address; out_port = 0x00.
REQ-029 Write DATA 0xA5, write OUTSET 0x0F, write OUTCLEAR 0x81 -> DATA reads 0x2E; out_port = 0x2E.
REQ-030 DATA 0x00, BLINK_MASK 0x03, PERIOD 3 -> out_port 0x00 for 4 clocks after the PERIOD write, then 0x03 for 4 clocks, repeating; STATUS tracks phase.
REQ-031 While phase = 1, write PERIOD 0 -> next cycle phase = 0, out_port = DATA, count frozen.
REQ-032 Write with chipselect = 0 to DATA 0xFF -> DATA unchanged; write to address 6 -> no register changes; writedata 0xFFFF_FF12 to DATA -> DATA = 0x12.
REQ-033 Assert reset_n during active blink, between clock edges -> out_port = RESET_VALUE and readdata = 0 without waiting for a clock.
